dvi_tmds_encoder: RTL

//  Downstream of the VGA timing/pixel stage. Consumes the 24-bit RGB pixel, hsync, vsync
//  and de in the pixel clock domain. Produces three DVI 1.0 TMDS 10-bit symbols per clock

---
 rtl/dvi_tmds_encoder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three channels, 8b/10b with running-disparity balancing.
// Define TMDS_OUT_REG_EN to add a third output register (latency 3 instead of 2).
module dvi_tmds_encoder #(
   parameter logic [1:0] CH1_CTRL = 2'b00,
   parameter logic [1:0] CH2_CTRL = 2'b00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] vga_r,
   input  logic [7:0] vga_g,
   input  logic [7:0] vga_b,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       de,
   output logic [9:0] tmds_ch0,
   output logic [9:0] tmds_ch1,
   output logic [9:0] tmds_ch2
);

   localparam logic [9:0] CTRL_00 = 10'h354;
   localparam logic [9:0] CTRL_01 = 10'h0AB;
   localparam logic [9:0] CTRL_10 = 10'h154;
   localparam logic [9:0] CTRL_11 = 10'h2AB;

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] code;
      case (c)
         2'b00:   code = CTRL_00;
         2'b01:   code = CTRL_01;
         2'b10:   code = CTRL_10;
         default: code = CTRL_11;
      endcase
      return code;
   endfunction

   // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
   function automatic logic [8:0] tmds_qm(input logic [7:0] d);
      logic [3:0] n1d;
      logic       use_xnor;
      logic [8:0] q;
      n1d      = 4'($countones(d));
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic [7:0] pix     [3];
   logic [1:0] ctrl_in [3];
   logic [9:0] sym_out [3];
   logic       de_q;

   assign pix[0]     = vga_b;
   assign pix[1]     = vga_g;
   assign pix[2]     = vga_r;
   assign ctrl_in[0] = {vsync, hsync};
   assign ctrl_in[1] = CH1_CTRL;
   assign ctrl_in[2] = CH2_CTRL;

   always_ff @(posedge clk) begin
      if (rst) de_q <= 1'b0;
      else     de_q <= de;
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic [8:0]        qm_d, qm_q;
      logic [1:0]        ctrl_q;
      logic [9:0]        sym_d, sym_q;
      logic signed [4:0] cnt_d, cnt_q;
      logic [3:0]        n1;
      logic signed [5:0] c6, d6, q2, cnt_n;

      assign qm_d = tmds_qm(pix[ch]);

      always_ff @(posedge clk) begin
         if (rst) begin
            qm_q   <= '0;
            ctrl_q <= 2'b00;
         end else begin
            qm_q   <= qm_d;
            ctrl_q <= ctrl_in[ch];
         end
      end

      // 6-bit intermediate keeps the update exact before narrowing to the 5-bit counter.
      always_comb begin
         n1    = 4'($countones(qm_q[7:0]));
         c6    = {cnt_q[4], cnt_q};
         d6    = $signed({1'b0, n1, 1'b0}) - 6'sd8;
         q2    = qm_q[8] ? 6'sd2 : 6'sd0;
         sym_d = ctrl_code(ctrl_q);
         cnt_n = '0;
         if (de_q) begin
            if ((cnt_q == 5'sd0) || (n1 == 4'd4)) begin
               sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
               cnt_n = qm_q[8] ? (c6 + d6) : (c6 - d6);
            end else if (((cnt_q > 5'sd0) && (n1 > 4'd4)) ||
                         ((cnt_q < 5'sd0) && (n1 < 4'd4))) begin
               sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
               cnt_n = c6 + q2 - d6;
            end else begin
               sym_d = {1'b0, qm_q[8], qm_q[7:0]};
               cnt_n = c6 - (6'sd2 - q2) + d6;
            end
         end
         cnt_d = cnt_n[4:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sym_q <= CTRL_00;
            cnt_q <= 5'sd0;
         end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
         end
      end

`ifdef TMDS_OUT_REG_EN
      logic [9:0] out_q;
      always_ff @(posedge clk) begin
         if (rst) out_q <= CTRL_00;
         else     out_q <= sym_q;
      end
      assign sym_out[ch] = out_q;
`else
      assign sym_out[ch] = sym_q;
`endif
   end

   assign tmds_ch0 = sym_out[0];
   assign tmds_ch1 = sym_out[1];
   assign tmds_ch2 = sym_out[2];

endmodule
